// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the iterative divider, the CPU top and the
// hazard unit.
//   div_state_e       : divider FSM states (IDLE, RUN, FIX, DONE)
//   DIV_WIDTH_DEFAULT : default operand/result width
//   div_cnt_w()       : width of the step counter for a given operand width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Step counter counts WIDTH-1 down to 0. Keep at least one bit.
  function automatic int div_cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/iter_divider_if.sv
// iter_divider_if -- request/response bundle between the execute stage and
// the iterative divider.
//   master : execute stage side (drives start/operands/flush)
//   slave  : divider side (drives busy/done/results)
interface iter_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor, flush,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor, flush,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// div_step -- one combinational radix-2 restoring division iteration.
//   rem, quo : current partial remainder / quotient-shift register
//   dvs      : divisor magnitude
//   rem_n    : partial remainder after shift + trial subtract + restore
//   quo_n    : quotient register shifted left with the new quotient bit
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Top bit of quo shifts into the remainder; one extra bit catches the borrow.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign rem_n   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_n   = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/iter_divider.sv
// iter_divider -- multi-cycle radix-2 restoring divider (DIV/DIVU).
//   clock, reset_n : clock, asynchronous active-low reset
//   bus (slave)    : start/signed_op/dividend/divisor/flush in,
//                    busy/done/quotient(LO)/remainder(HI)/div_by_zero out
// One quotient bit per cycle; done appears WIDTH+1 edges after the start edge.
// Build option: define ITER_DIVIDER_SIGNED_EN to honour signed_op (operand
// magnitudes and result sign correction). Without it every op is unsigned and
// FIX is a plain register stage.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic          clock,
  input  logic          reset_n,
  iter_divider_if.slave bus
);
  localparam int CW = div_cnt_w(WIDTH);

  div_state_e       state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] q_res, r_res;
  logic [WIDTH-1:0] quo_o, rem_o;
  logic             dz, dbz_o;
  logic             accept;

  // New operands are taken in IDLE or in DONE (back-to-back); flush wins.
  assign accept = bus.start && !bus.flush && (state == IDLE || state == DONE);

`ifdef ITER_DIVIDER_SIGNED_EN
  logic dvd_neg, dvs_neg;
  logic neg_q, neg_r;

  assign dvd_neg = bus.signed_op & bus.dividend[WIDTH-1];
  assign dvs_neg = bus.signed_op & bus.divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
  assign dvs_mag = dvs_neg ? -bus.divisor  : bus.divisor;
  assign q_res   = neg_q ? -quo : quo;
  // For divide-by-zero rem holds |dividend|, so this restores the original bits.
  assign r_res   = neg_r ? -rem : rem;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dvd_neg ^ dvs_neg;
      neg_r <= dvd_neg;
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = bus.signed_op;
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
  assign q_res   = quo;
  assign r_res   = rem;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem   (rem),
    .quo   (quo),
    .dvs   (dvs),
    .rem_n (rem_step),
    .quo_n (quo_step)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (cnt == '0) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    state_n = accept ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.flush) state_n = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      dz    <= 1'b0;
      quo_o <= '0;
      rem_o <= '0;
      dbz_o <= 1'b0;
    end else begin
      if (accept) begin
        rem <= '0;
        quo <= dvd_mag;
        dvs <= dvs_mag;
        dz  <= (bus.divisor == '0);
        cnt <= CW'(WIDTH - 1);
      end else if (state == RUN && !bus.flush) begin
        rem <= rem_step;
        quo <= quo_step;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      // Outputs only move on a completed FIX, so a flush leaves them held.
      if (state == FIX && !bus.flush) begin
        quo_o <= dz ? '1 : q_res;
        rem_o <= r_res;
        dbz_o <= dz;
      end
    end
  end

  assign bus.busy        = (state == RUN) || (state == FIX);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quo_o;
  assign bus.remainder   = rem_o;
  assign bus.div_by_zero = dbz_o;
endmodule
